// File: rtl/nibble_comp_pkg.sv
// Shared types and constants for the nibble-serial load-and-compare block:
// FSM state encoding, nibble width and the registered result encoding.
package nibble_comp_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_LT   = 2'd1,
    RES_GT   = 2'd2,
    RES_EQ   = 2'd3
  } res_t;

endpackage

// File: rtl/nibble_cmp.sv
// Single-nibble magnitude comparator. With sgn=1 the nibble is treated as a
// 4-bit two's-complement value, otherwise as unsigned.
module nibble_cmp
  import nibble_comp_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             sgn,
  output logic             lt,
  output logic             gt
);

  logic [NIB_W-1:0] a_k;
  logic [NIB_W-1:0] b_k;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    a_k = {a[NIB_W-1] ^ sgn, a[NIB_W-2:0]};
    b_k = {b[NIB_W-1] ^ sgn, b[NIB_W-2:0]};
    lt  = (a_k < b_k);
    gt  = (a_k > b_k);
  end

endmodule

// File: rtl/nibble_load_comp.sv
// Nibble-serial operand loader and MSB-first comparator.
// Operands A and B are loaded four bits at a time (LSB nibble first). A start
// compares the top nibble on the start edge itself and then walks down one
// nibble per cycle, exiting on the first difference.
// Optional feature: define NIBBLE_COMP_SIGNED_EN to honour sgn (top nibble
// treated as signed); otherwise sgn is ignored and all compares are unsigned.
module nibble_load_comp
  import nibble_comp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] y,
  input  logic       ld_a,
  input  logic       ld_b,
  input  logic       clr,
  input  logic       start,
  input  logic       sgn,
  output logic       a_full,
  output logic       b_full,
  output logic       busy,
  output logic       done,
  output logic       l,
  output logic       g,
  output logic       e
);

  localparam int NNIB = WIDTH / NIB_W;
  localparam int KW   = $clog2(NNIB);
  localparam int CW   = $clog2(NNIB + 1);

  state_t           state_q, state_d;
  res_t             res_q, res_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    cnt_a_q, cnt_b_q;

  logic             in_cmp;
  logic             ld_a_ok, ld_b_ok, start_ok;
  logic [KW-1:0]    cmp_k;
  logic [NIB_W-1:0] a_nib, b_nib;
  logic             nib_sgn, nib_lt, nib_gt;

  assign in_cmp = (state_q == ST_CMP);
  assign a_full = (cnt_a_q == CW'(NNIB));
  assign b_full = (cnt_b_q == CW'(NNIB));

  // clr outranks loads and start; loads into a full operand are dropped.
  assign ld_a_ok  = ld_a & ~clr & ~in_cmp & ~a_full;
  assign ld_b_ok  = ld_b & ~clr & ~in_cmp & ~b_full;
  assign start_ok = start & ~clr & ~in_cmp & a_full & b_full;

  // On the start edge the top nibble is examined directly; afterwards k walks.
  assign cmp_k = in_cmp ? k_q : KW'(NNIB - 1);

`ifdef NIBBLE_COMP_SIGNED_EN
  logic sgn_q;
  logic sgn_eff;

  // On the start cycle sgn is used live, in CMP the latched copy applies.
  assign sgn_eff = in_cmp ? sgn_q : sgn;
  assign nib_sgn = sgn_eff & (cmp_k == KW'(NNIB - 1));

  // Latch the signedness request together with an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sgn_q <= 1'b0;
    else if (clr)      sgn_q <= 1'b0;
    else if (start_ok) sgn_q <= sgn;
  end
`else
  logic unused_sgn;

  assign unused_sgn = sgn;
  assign nib_sgn    = 1'b0;
`endif

  // Select nibble cmp_k of each operand for the shared comparator.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NNIB; i++) begin
      if (cmp_k == KW'(i)) begin
        a_nib = a_q[i*NIB_W +: NIB_W];
        b_nib = b_q[i*NIB_W +: NIB_W];
      end
    end
  end

  nibble_cmp u_nibble_cmp (
    .a   (a_nib),
    .b   (b_nib),
    .sgn (nib_sgn),
    .lt  (nib_lt),
    .gt  (nib_gt)
  );

  // FSM state register plus walking index and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= ST_IDLE;
      k_q     <= '0;
      res_q   <= RES_NONE;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      res_q   <= res_d;
    end
  end

  // Next-state logic: start handling, MSB-first walk with early exit.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    res_d   = res_q;
    if (clr) begin
      state_d = ST_IDLE;
      k_d     = '0;
      res_d   = RES_NONE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            if (nib_lt) begin
              state_d = ST_DONE;
              res_d   = RES_LT;
            end else if (nib_gt) begin
              state_d = ST_DONE;
              res_d   = RES_GT;
            end else begin
              state_d = ST_CMP;
              res_d   = RES_NONE;
              k_d     = KW'(NNIB - 2);
            end
          end else if (ld_a_ok || ld_b_ok) begin
            state_d = ST_IDLE;
            res_d   = RES_NONE;
          end
        end
        ST_CMP: begin
          if (nib_lt) begin
            state_d = ST_DONE;
            res_d   = RES_LT;
          end else if (nib_gt) begin
            state_d = ST_DONE;
            res_d   = RES_GT;
          end else if (k_q == '0) begin
            state_d = ST_DONE;
            res_d   = RES_EQ;
          end else begin
            k_d = k_q - 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          k_d     = '0;
          res_d   = RES_NONE;
        end
      endcase
    end
  end

  // Operand registers and nibble fill counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else if (clr) begin
      a_q     <= '0;
      b_q     <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      for (int i = 0; i < NNIB; i++) begin
        if (ld_a_ok && cnt_a_q == CW'(i)) a_q[i*NIB_W +: NIB_W] <= y;
        if (ld_b_ok && cnt_b_q == CW'(i)) b_q[i*NIB_W +: NIB_W] <= y;
      end
      if (ld_a_ok) cnt_a_q <= cnt_a_q + 1'b1;
      if (ld_b_ok) cnt_b_q <= cnt_b_q + 1'b1;
    end
  end

  assign busy = in_cmp;
  assign done = (state_q == ST_DONE);
  assign l    = done && (res_q == RES_LT);
  assign g    = done && (res_q == RES_GT);
  assign e    = done && (res_q == RES_EQ);

endmodule

// File: tb/tb_nibble_load_comp.sv
// Scoreboard bench for nibble_load_comp: a WIDTH=8 and a WIDTH=16 instance.
// Stimulus pushes the expected {l,g,e} and latency per start; a monitor pops
// and compares whenever done is seen after the start edge.
module tb_nibble_load_comp;

  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;
`ifdef NIBBLE_COMP_SIGNED_EN
  localparam logic [2:0] SGN_80_01 = LT;
`else
  localparam logic [2:0] SGN_80_01 = GT;
`endif

  typedef struct {
    int         d;
    logic [2:0] lge;
    int         lat;
    int         start_cyc;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] y [2];
  logic [1:0] ld_a, ld_b, clr, start, sgn;
  logic [1:0] a_full, b_full, busy, done, l, g, e;

  exp_t sbq[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  nibble_load_comp #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .y(y[0]), .ld_a(ld_a[0]), .ld_b(ld_b[0]),
    .clr(clr[0]), .start(start[0]), .sgn(sgn[0]),
    .a_full(a_full[0]), .b_full(b_full[0]), .busy(busy[0]), .done(done[0]),
    .l(l[0]), .g(g[0]), .e(e[0])
  );

  nibble_load_comp #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .y(y[1]), .ld_a(ld_a[1]), .ld_b(ld_b[1]),
    .clr(clr[1]), .start(start[1]), .sgn(sgn[1]),
    .a_full(a_full[1]), .b_full(b_full[1]), .busy(busy[1]), .done(done[1]),
    .l(l[1]), .g(g[1]), .e(e[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [6:0] outs(input int d);
    return {a_full[d], b_full[d], busy[d], done[d], l[d], g[d], e[d]};
  endfunction

  task automatic load(input int d, input bit to_a, input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      y[d] = v[4*i +: 4];
      if (to_a) ld_a[d] = 1'b1;
      else      ld_b[d] = 1'b1;
      @(negedge clk);
    end
    ld_a[d] = 1'b0;
    ld_b[d] = 1'b0;
  endtask

  task automatic go(input int d, input logic s, input logic [2:0] lge, input int lat, input string name);
    exp_t x;
    x.d = d; x.lge = lge; x.lat = lat; x.start_cyc = cyc + 1; x.name = name;
    sbq.push_back(x);
    sgn[d]   = s;
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sbq.size() > 0; i++) @(negedge clk);
  endtask

  task automatic do_clr(input int d);
    clr[d] = 1'b1;
    @(negedge clk);
    clr[d] = 1'b0;
  endtask

  // Monitor: pop the oldest expectation once done is seen after its start edge.
  initial begin
    forever begin
      exp_t x;
      @(negedge clk);
      if (rst_n && sbq.size() > 0) begin
        x = sbq[0];
        if (cyc >= x.start_cyc) begin
          if (done[x.d]) begin
            void'(sbq.pop_front());
            check({x.name, " lge"}, {29'd0, l[x.d], g[x.d], e[x.d]}, {29'd0, x.lge});
            check({x.name, " latency"}, cyc - x.start_cyc + 1, x.lat);
          end else if (cyc - x.start_cyc + 1 > 20) begin
            void'(sbq.pop_front());
            check({x.name, " done timeout"}, {31'd0, done[x.d]}, 32'd1);
          end
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) y[d] = '0;
    ld_a = '0; ld_b = '0; clr = '0; start = '0; sgn = '0;

    #3;
    check("reset outs w8", outs(0), 7'd0);
    check("reset outs w16", outs(1), 7'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero operands: top nibble equal, nibble 0 equal -> e after 2 edges.
    load(0, 1, 64'h00, 2);
    load(0, 0, 64'h00, 2);
    check("full w8", {30'd0, a_full[0], b_full[0]}, 32'd3);
    go(0, 1'b0, EQ, 2, "t1 0x00 vs 0x00");
    drain();

    // 0x80 vs 0x01 decided on the top nibble alone.
    do_clr(0);
    check("clr outs w8", outs(0), 7'd0);
    load(0, 1, 64'h80, 2);
    load(0, 0, 64'h01, 2);
    go(0, 1'b0, GT, 1, "t2 unsigned");
    drain();
    go(0, 1'b1, SGN_80_01, 1, "t2 signed");
    drain();

    // Top nibble equal, low nibble smaller.
    do_clr(0);
    load(0, 1, 64'h3C, 2);
    load(0, 0, 64'h3D, 2);
    go(0, 1'b0, LT, 2, "t2b 0x3c vs 0x3d");
    drain();

    // 0x55 vs 0x54, then an extra ld_a must not alter A.
    do_clr(0);
    load(0, 1, 64'h55, 2);
    load(0, 0, 64'h54, 2);
    go(0, 1'b0, GT, 2, "t3 0x55 vs 0x54");
    drain();
    load(0, 1, 64'h0, 1);
    check("t3 a_full after extra load", {31'd0, a_full[0]}, 32'd1);
    go(0, 1'b0, GT, 2, "t3 restart");
    drain();

    // WIDTH=16: start with B only 3 nibbles loaded is ignored.
    load(1, 1, 64'h1234, 4);
    load(1, 0, 64'h234, 3);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    check("t4 partial b busy/done/b_full", {29'd0, busy[1], done[1], b_full[1]}, 32'd0);
    load(1, 0, 64'h1, 1);
    go(1, 1'b0, EQ, 4, "t4 0x1234 eq");
    check("t4 busy after start", {31'd0, busy[1]}, 32'd1);
    drain();

    // WIDTH=16: clr on the 2nd CMP cycle.
    do_clr(1);
    load(1, 1, 64'hABCD, 4);
    load(1, 0, 64'hABCD, 4);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    check("t5 busy cmp1", {31'd0, busy[1]}, 32'd1);
    @(negedge clk);
    clr[1] = 1'b1;
    @(negedge clk);
    clr[1] = 1'b0;
    check("t5 outs after clr", outs(1), 7'd0);

    // Asynchronous reset in the middle of CMP.
    load(1, 1, 64'hABCD, 4);
    load(1, 0, 64'hABCD, 4);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    check("t6 busy before reset", {31'd0, busy[1]}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6 async outs w16", outs(1), 7'd0);
    check("t6 async outs w8", outs(0), 7'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal operation resumes after reset.
    load(0, 1, 64'h01, 2);
    load(0, 0, 64'h02, 2);
    go(0, 1'b0, LT, 2, "t7 after reset");
    drain();
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/nibble_load_comp.md
NIBBLE_LOAD_COMP -- requirements
Module: nibble_load_comp

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits; legal values are multiples of 4 in the range 8..64.
REQ-002 SHALL have derived constant NNIB = WIDTH/4, the nibble count per operand.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port y, input, 4 bits: nibble data for operand loading.
REQ-006 SHALL have port ld_a / ld_b, input, 1 bit each: strobes that load y into the next nibble of A / B.
REQ-007 SHALL have port clr, input, 1 bit: synchronous clear of operands, counters and results.
REQ-008 SHALL have port start, input, 1 bit: request a comparison.
REQ-009 SHALL have port sgn, input, 1 bit: 1 selects two's-complement comparison; sampled with start.
REQ-010 SHALL have ports a_full / b_full, output, 1 bit each: all NNIB nibbles of A / B are loaded.
REQ-011 SHALL have port busy, output, 1 bit: comparison in progress.
REQ-012 SHALL have port done, output, 1 bit: result valid.
REQ-013 SHALL have ports l / g / e, output, 1 bit each: A<B, A>B, A==B; one-hot when done=1, all 0 otherwise.

Function
REQ-014 SHALL implement FSM states IDLE, CMP and DONE; IDLE accepts loads and start.
REQ-015 SHALL, for ld_a in IDLE or DONE with A not full, write y to nibble index cnt_a (LSB nibble first) and increment cnt_a; ld_b behaves the same on B/cnt_b.
REQ-016 SHALL let ld_a and ld_b in the same cycle both load the same y.
REQ-017 SHALL ignore loads into a full operand (no wrap) and all loads while busy; a load in DONE returns the FSM to IDLE and clears done/l/g/e.
REQ-018 SHALL, on start in IDLE or DONE with a_full & b_full, enter CMP, set busy, clear done/l/g/e, latch sgn and set index k=NNIB-1; start with either operand not full SHALL be ignored.
REQ-019 SHALL, in CMP, compare nibble k of A and B each cycle, MSB nibble first.
REQ-020 SHALL treat the top nibble (k=NNIB-1) as signed 4-bit when latched sgn=1, and every other nibble as unsigned.
REQ-021 SHALL, on the first differing nibble, register l or g and move to DONE at that edge (early exit); if nibble 0 is equal, it SHALL register e=1 and move to DONE.
REQ-022 SHALL give a latency from the start edge to done=1 of m edges, where m is the number of nibbles examined (1..NNIB).
REQ-023 SHALL hold done and the result in DONE until clr, a load, or an accepted start; operands are retained, so re-start recompares.
REQ-024 SHALL, on clr in any state, go to IDLE and zero operands, counters, busy, done and l/g/e next edge; clr SHALL take priority over start and loads in the same cycle.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force state IDLE, A=B=0, cnt_a=cnt_b=0, k=0 and all outputs 0, including mid-CMP.
REQ-026 SHALL resume operation on the first clk edge after rst_n deasserts.

Configuration
REQ-027 SHALL, when macro NIBBLE_COMP_SIGNED_EN is defined, implement sgn as in REQ-020.
REQ-028 SHALL, when NIBBLE_COMP_SIGNED_EN is undefined, keep the sgn port but ignore it, so every comparison is unsigned with no signed logic synthesised.

Structure
REQ-029 SHALL place the FSM state enum, NIB_W=4 and the result encoding (LT/GT/EQ) in shared package nibble_comp_pkg.
REQ-030 SHALL implement the per-nibble compare (4-bit a, b, signed flag -> lt, gt) in sub-module nibble_cmp, instantiated once.

Verification
REQ-031 SHALL cover: WIDTH=8, load A=0x00 and B=0x00, start -> e=1, done 2 edges after start.
REQ-032 SHALL cover: WIDTH=8, A=0x80, B=0x01, sgn=0 -> g=1 after 1 edge; same operands with sgn=1 (macro on) -> l=1 after 1 edge; with macro off -> g=1.
REQ-033 SHALL cover: WIDTH=8, A=0x55, B=0x54 -> l=0, g=1, done 2 edges after start; then a third ld_a is ignored and a_full stays 1.
REQ-034 SHALL cover: WIDTH=16, start issued with only 3 nibbles of B loaded -> ignored (busy stays 0); after the 4th nibble of B, start -> busy=1.
REQ-035 SHALL cover: WIDTH=16, equal operands, clr asserted on the 2nd CMP cycle -> next edge IDLE, all outputs 0, a_full=b_full=0.
REQ-036 SHALL cover: rst_n pulsed low mid-CMP -> outputs 0 immediately, without waiting for a clk edge.
